// File: rtl/ntlm_rom_arbiter.sv
// Round-robin arbiter and burst sequencer that shares one registered-output
// NTLMv2 packet/hash ROM between NREQ cracker cores.

// Per-core request slice: unpacks this core's start address and length and
// flags whether the core sits above the round-robin pointer.
module ntlm_rom_arbiter_lane #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3,
  parameter int LANE   = 0
) (
  input  logic [ID_W-1:0]        ptr_i,
  input  logic                   req_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*LEN_W-1:0]  req_len_i,
  output logic                   hi_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [LEN_W-1:0]       len_o
);

  assign hi_o   = req_i && (ID_W'(LANE) > ptr_i);
  assign addr_o = req_addr_i[LANE*ADDR_W +: ADDR_W];
  assign len_o  = req_len_i[LANE*LEN_W +: LEN_W];

endmodule

module ntlm_rom_arbiter #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int ADDR_W    = 3,
  parameter int LEN_W     = 3,
  parameter int WORD_W    = 512,
  parameter int ROM_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        req_ack,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WORD_W-1:0]      rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [WORD_W-1:0]      rom_datai,
  input  logic [WORD_W-1:0]      rom_data,
  output logic                   rom_cs_n,
  output logic                   rom_oe_n,
  output logic                   rom_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [31:0] DEPTH_U = 32'(ROM_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [WORD_W-1:0] data;
    logic              last;
    logic              err;
  } rsp_t;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  rsp_t              rsp_q, rsp_d;

  logic [NREQ-1:0]             req_hi;
  logic [NREQ-1:0][ADDR_W-1:0] addr_a;
  logic [NREQ-1:0][LEN_W-1:0]  len_a;
  logic [ID_W-1:0]             win_hi, win_lo, win;
  logic                        any_hi;
  logic                        in_range;

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
      ntlm_rom_arbiter_lane #(
        .NREQ  (NREQ),
        .ID_W  (ID_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W),
        .LANE  (g)
      ) u_lane (
        .ptr_i     (ptr_q),
        .req_i     (req[g]),
        .req_addr_i(req_addr),
        .req_len_i (req_len),
        .hi_o      (req_hi[g]),
        .addr_o    (addr_a[g]),
        .len_o     (len_a[g])
      );
    end
  endgenerate

  // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    any_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        win_hi = ID_W'(i);
        any_hi = 1'b1;
      end
      if (req[i]) win_lo = ID_W'(i);
    end
    win = any_hi ? win_hi : win_lo;
  end

  assign in_range = (32'(cur_q) < DEPTH_U);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    ack_d   = '0;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d      = win;
          ptr_d      = win;
          cur_d      = addr_a[win];
          rem_d      = len_a[win];
          ack_d[win] = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        // ROM output now reflects cur_q; out-of-range words are zeroed and flagged.
        rsp_d.valid = 1'b1;
        rsp_d.id    = gnt_q;
        rsp_d.data  = in_range ? rom_data : '0;
        rsp_d.last  = (rem_q == '0);
        rsp_d.err   = !in_range;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_d.valid = 1'b0;
          if (rem_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            rem_d   = rem_q - LEN_W'(1);
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(NREQ - 1);
      gnt_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      ack_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
    end
  end

  // The ROM address register doubles as the burst cursor.
  assign rom_addr  = cur_q;
  assign rom_datai = '0;
  assign rom_cs_n  = (state_q != S_READ);
  assign rom_oe_n  = (state_q != S_READ);
  assign rom_we_n  = 1'b1;
  assign busy      = (state_q != S_IDLE);
  assign req_ack   = ack_q;
  assign rsp_valid = rsp_q.valid;
  assign rsp_id    = rsp_q.id;
  assign rsp_data  = rsp_q.data;
  assign rsp_last  = rsp_q.last;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_ntlm_rom_arbiter.sv
// Directed plus randomized bench for ntlm_rom_arbiter against a
// burst/round-robin reference model and a registered ROM model.
module tb_ntlm_rom_arbiter;

  localparam int NREQ      = 4;
  localparam int ID_W      = 2;
  localparam int ADDR_W    = 4;
  localparam int LEN_W     = 3;
  localparam int WORD_W    = 512;
  localparam int ROM_DEPTH = 8;
  localparam int NADDR     = 1 << ADDR_W;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*LEN_W-1:0]  req_len = '0;
  logic [NREQ-1:0]        req_ack;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [ID_W-1:0]        rsp_id;
  logic [WORD_W-1:0]      rsp_data;
  logic                   rsp_last;
  logic                   rsp_err;
  logic                   busy;
  logic [ADDR_W-1:0]      rom_addr;
  logic [WORD_W-1:0]      rom_datai;
  logic [WORD_W-1:0]      rom_data;
  logic                   rom_cs_n;
  logic                   rom_oe_n;
  logic                   rom_we_n;

  ntlm_rom_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .WORD_W(WORD_W), .ROM_DEPTH(ROM_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
    .req_len(req_len), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
    .rom_addr(rom_addr), .rom_datai(rom_datai), .rom_data(rom_data),
    .rom_cs_n(rom_cs_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n)
  );

  always #5 clock = ~clock;

  // Registered ROM: full address space populated so zero-forcing is visible.
  logic [WORD_W-1:0] mem [NADDR];
  always @(posedge clock) if (!rom_cs_n) rom_data <= mem[rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m;
  int a_m [NREQ];
  int l_m [NREQ];

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [WORD_W-1:0] exp_data(input int a);
    return (a < ROM_DEPTH) ? mem[a] : '0;
  endfunction

  task automatic set_req(input int c, input int a, input int l);
    req_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
    req_len[c*LEN_W +: LEN_W]    = LEN_W'(l);
    a_m[c] = a;
    l_m[c] = l;
  endtask

  task automatic check_reset_vals();
    chk("rst_ack", req_ack, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_last", rsp_last, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_datai", rom_datai, 0);
    chk("rst_cs_n", rom_cs_n, 1);
    chk("rst_oe_n", rom_oe_n, 1);
    chk("rst_we_n", rom_we_n, 1);
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    #1;
    check_reset_vals();
    step();
    step();
    check_reset_vals();
    reset = 1'b1;
    ptr_m = NREQ - 1;
  endtask

  // Waits for the grant of the currently driven req vector; returns at the ack sample.
  task automatic wait_ack(output int w);
    int exp_w;
    int n;
    exp_w = rr_pick(req, ptr_m);
    n = 0;
    do begin
      step();
      n++;
    end while (req_ack == '0 && n < 12);
    chk("ack_latency", n, 1);
    chk("ack_onehot", req_ack, 1 << exp_w);
    w     = exp_w;
    ptr_m = exp_w;
  endtask

  // Starts at the ack/acceptance sample where the ROM read is in progress.
  task automatic burst(input int w, input int addr, input int len, input int stall_at,
                       input int stall_n, input bit rnd, input int abort_at);
    int a;
    int s;
    for (int k = 0; k <= len; k++) begin
      a = (addr + k) % NADDR;
      chk("read_cs_n", rom_cs_n, 0);
      chk("read_oe_n", rom_oe_n, 0);
      chk("read_addr", rom_addr, a);
      chk("read_busy", busy, 1);
      chk("read_valid", rsp_valid, 0);
      step();
      chk("capt_valid", rsp_valid, 0);
      chk("capt_cs_n", rom_cs_n, 1);
      chk("capt_ack", req_ack, 0);
      step();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, w);
      chk("rsp_data", rsp_data, exp_data(a));
      chk("rsp_last", rsp_last, (k == len));
      chk("rsp_err", rsp_err, (a >= ROM_DEPTH));
      if (k == abort_at) return;
      s = rnd ? int'($urandom_range(0, 3)) : ((k == stall_at) ? stall_n : 0);
      if (s > 0) rsp_ready = 1'b0;
      for (int j = 0; j < s; j++) begin
        step();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, exp_data(a));
        chk("hold_last", rsp_last, (k == len));
        chk("hold_cs_n", rom_cs_n, 1);
      end
      rsp_ready = 1'b1;
      step();
      if (k == len) begin
        chk("end_valid", rsp_valid, 0);
        chk("end_busy", busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int order [5];
    for (int i = 0; i < NADDR; i++) begin
      for (int j = 0; j < WORD_W / 32; j++) mem[i][j*32 +: 32] = $urandom;
      mem[i][0] = 1'b1;
    end
    mem[7][127:0] = 128'h7a7315c2a0195d74381fff267cc6a15e;
    order = '{0, 1, 2, 3, 0};

    // Reset state.
    do_reset();
    rsp_ready = 1'b1;

    // Single fetch of the NTLM hash word.
    set_req(0, 7, 0);
    req = 4'b0001;
    wait_ack(w);
    req = '0;
    burst(w, 7, 0, -1, 0, 1'b0, -1);

    // Six-word burst with ready held high.
    set_req(1, 1, 5);
    req = 4'b0010;
    wait_ack(w);
    req = '0;
    burst(w, 1, 5, -1, 0, 1'b0, -1);

    // Contention from a fresh pointer: all four re-request after each ack.
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < NREQ; c++) set_req(c, c + 2, 0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(w);
      chk("rr_order", w, order[g]);
      req[w] = 1'b0;
      burst(w, w + 2, 0, -1, 0, 1'b0, -1);
      req[w] = 1'b1;
    end
    req = '0;
    step();

    // Backpressure for 5 cycles on the middle word.
    set_req(3, 2, 2);
    req = 4'b1000;
    wait_ack(w);
    req = '0;
    burst(w, 2, 2, 1, 5, 1'b0, -1);

    // Burst that runs past the populated ROM depth.
    set_req(2, 6, 3);
    req = 4'b0100;
    wait_ack(w);
    req = '0;
    burst(w, 6, 3, 2, 2, 1'b0, -1);

    // Reset on the third word of a long burst, then core 2 must win first.
    set_req(1, 0, 5);
    req = 4'b0010;
    wait_ack(w);
    req = '0;
    burst(w, 0, 5, -1, 0, 1'b0, 2);
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 3, 1);
    set_req(3, 4, 0);
    req = 4'b1100;
    wait_ack(w);
    chk("post_reset_winner", w, 2);
    req = '0;
    burst(w, 3, 1, -1, 0, 1'b0, -1);

    // Randomized requests; addresses/lengths change after the grant.
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < NREQ; c++)
        set_req(c, int'($urandom_range(0, NADDR - 1)), int'($urandom_range(0, 7)));
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      wait_ack(w);
      begin
        int ga;
        int gl;
        ga = a_m[w];
        gl = l_m[w];
        req = '0;
        req_addr = NREQ*ADDR_W'($urandom);
        req_len  = NREQ*LEN_W'($urandom);
        burst(w, ga, gl, -1, 0, 1'b1, -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
